// File: rtl/uart_rx.sv
// UART receiver: recovers 8N1 frames (8E1 when UART_RX_PARITY_EN is defined) from rx,
// timing bits with a clocks-per-bit counter off the system clock.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 868
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       valid,
    output logic       framing_err,
    output logic       parity_err,
    output logic       busy
);

    localparam int unsigned HALF  = CLKS_PER_BIT / 2;
    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP,
        BREAK
    } state_t;

    state_t           state;
    logic             s1;
    logic             s2;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       idx;
    logic [7:0]       shreg;
`ifdef UART_RX_PARITY_EN
    logic             par_bad;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            s1          <= 1'b1;
            s2          <= 1'b1;
            cnt         <= '0;
            idx         <= '0;
            shreg       <= '0;
            data_out    <= '0;
            valid       <= 1'b0;
            framing_err <= 1'b0;
            busy        <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
            par_bad     <= 1'b0;
`endif
        end else begin
            s1          <= rx;
            s2          <= s1;
            valid       <= 1'b0;
            framing_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    cnt <= '0;
                    idx <= '0;
                    if (!s2) begin
                        state <= START;
                        busy  <= 1'b1;
                    end
                end
                // Mid-start-bit check rejects glitches shorter than half a bit.
                START: begin
                    if (cnt == HALF_LAST) begin
                        cnt <= '0;
                        if (!s2) begin
                            state <= DATA;
                        end else begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (cnt == BIT_LAST) begin
                        cnt   <= '0;
                        shreg <= {s2, shreg[7:1]};
                        if (idx == 3'd7) begin
                            idx   <= '0;
`ifdef UART_RX_PARITY_EN
                            state <= PARITY;
`else
                            state <= STOP;
`endif
                        end else begin
                            idx <= idx + 3'd1;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`ifdef UART_RX_PARITY_EN
                PARITY: begin
                    if (cnt == BIT_LAST) begin
                        cnt     <= '0;
                        par_bad <= s2 ^ (^shreg);
                        state   <= STOP;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
`endif
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                STOP: begin
                    if (cnt == BIT_LAST) begin
                        cnt <= '0;
                        if (s2) begin
                            state <= IDLE;
                            busy  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            if (par_bad) begin
                                parity_err <= 1'b1;
                            end else begin
                                data_out <= shreg;
                                valid    <= 1'b1;
                            end
`else
                            data_out <= shreg;
                            valid    <= 1'b1;
`endif
                        end else begin
                            framing_err <= 1'b1;
                            state       <= BREAK;
                        end
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                // Held-low line must return high before another start is accepted.
                BREAK: begin
                    if (s2) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule
